// File: rtl/divider_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with start/busy/done handshake.
// Optional macro DIVIDER_FAST_SPECIAL_EN: B==0, signed overflow and A==0 bypass the iteration loop.
module divider_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK_0,
  input  logic            RST_0,
  input  logic            START_0,
  input  logic [1:0]      OP_0,
  input  logic [XLEN-1:0] A_0,
  input  logic [XLEN-1:0] B_0,
  input  logic            ABORT_0,
  output logic            BUSY_0,
  output logic            DONE_0,
  output logic [XLEN-1:0] RESULT_0
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [1:0]      op_q, op_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_signed;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   trial;

  always_comb begin
    is_signed = ~OP_0[0];
    a_abs     = (is_signed && A_0[XLEN-1]) ? (XLEN'(0) - A_0) : A_0;
    b_abs     = (is_signed && B_0[XLEN-1]) ? (XLEN'(0) - B_0) : B_0;
    // Shifted partial remainder minus divisor; MSB set means the subtraction underflowed
    trial     = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    if (ABORT_0) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (START_0) begin
            state_d = S_CALC;
            busy_d  = 1'b1;
            op_d    = OP_0;
            dvs_d   = b_abs;
            quo_d   = a_abs;
            rem_d   = '0;
            cnt_d   = CW'(XLEN);
            qneg_d  = is_signed & (A_0[XLEN-1] ^ B_0[XLEN-1]) & (B_0 != '0);
            rneg_d  = is_signed & A_0[XLEN-1];
`ifdef DIVIDER_FAST_SPECIAL_EN
            // Preload the final unsigned quotient/remainder so FIX applies the usual sign fixup
            if (B_0 == '0) begin
              state_d = S_FIX;
              quo_d   = '1;
              rem_d   = a_abs;
            end else if (is_signed && (A_0 == {1'b1, {(XLEN-1){1'b0}}}) && (B_0 == '1)) begin
              state_d = S_FIX;
              quo_d   = a_abs;
              rem_d   = '0;
            end else if (A_0 == '0) begin
              state_d = S_FIX;
              quo_d   = '0;
              rem_d   = '0;
            end
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          busy_d = 1'b1;
          rem_d  = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
          quo_d  = {quo_q[XLEN-2:0], ~trial[XLEN]};
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (op_q[1]) begin
            result_d = rneg_q ? (XLEN'(0) - rem_q) : rem_q;
          end else begin
            result_d = qneg_q ? (XLEN'(0) - quo_q) : quo_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_0) begin
    if (RST_0) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      op_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign BUSY_0   = busy_q;
  assign DONE_0   = done_q;
  assign RESULT_0 = result_q;

endmodule

// File: doc/divider_unit.md
Name: divider_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Companion to the pipelined multiplier in the execute stage: the multiplier produces products, this block produces quotients and remainders.
- Multi-cycle unit with a start/busy/done handshake. Execute stalls while BUSY_0 is high.

Parameters:
- XLEN, 32, operand and result width. The counter is $clog2(XLEN)+1 bits wide.

Ports:
- CLK_0  input  1  clock, all state on rising edge
- RST_0  input  1  synchronous active-high reset
- START_0  input  1  request a division; sampled only when BUSY_0=0
- OP_0  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with START_0
- A_0  input  XLEN  dividend (rs1); sampled with START_0
- B_0  input  XLEN  divisor (rs2); sampled with START_0
- ABORT_0  input  1  pipeline flush; cancels any operation in flight
- BUSY_0  output  1  operation in progress; START_0 ignored while high
- DONE_0  output  1  one-cycle pulse; RESULT_0 valid
- RESULT_0  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU); held until the next accepted START_0

Behaviour:
- Reset values: BUSY_0=0, DONE_0=0, RESULT_0=0, state=IDLE, counter=0. Reset overrides everything, including mid-operation; no DONE_0 is produced for the killed operation.
- States:
  - IDLE: BUSY_0=0.
  - CALC: BUSY_0=1.
  - FIX: BUSY_0=1.
  - DONE: BUSY_0=0, DONE_0=1.
- Transitions:
  - IDLE or DONE -> CALC on START_0=1 and ABORT_0=0. Latch OP_0. Latch |A| and |B| (signed ops) or raw values (unsigned ops). Record quotient and remainder negate flags: qneg = signed & (A[31]^B[31]) & (B!=0); rneg = signed & A[31]. Load remainder=0 and counter=XLEN.
  - CALC, each cycle: shift {rem,quo} left by 1; trial = rem - divisor (XLEN+1 bits); if non-negative, rem=trial and quo[0]=1. Decrement the counter. Go to FIX when the counter reaches 1.
  - FIX: apply the sign correction, select quotient or remainder into RESULT_0, then go to DONE.
  - DONE: lasts exactly one cycle, then goes to IDLE unless a new START_0 is accepted in that cycle, in which case it goes straight to CALC (back-to-back operation).
- Latency: START_0 accepted in cycle 0 gives DONE_0 high in cycle XLEN+2 (34). BUSY_0 is high in cycles 1..33.
- Special cases, RISC-V semantics, produced naturally by the datapath plus FIX:
  - Divide by zero: quotient = all ones (0xFFFFFFFF), remainder = A.
  - Signed overflow, A=0x80000000 and B=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- ABORT_0=1 in any state: next state is IDLE, DONE_0 stays 0, RESULT_0 keeps its previous value. If ABORT_0 and START_0 are high in the same cycle, ABORT_0 wins and the start is dropped.
- START_0 while BUSY_0=1: ignored. Operands are not re-sampled.
- A_0, B_0 and OP_0 may change freely after the START_0 cycle.

Optional Feature:
- Macro: DIVIDER_FAST_SPECIAL_EN.
- Defined:
  - On acceptance, detect B==0 or the signed-overflow case. Skip CALC and go IDLE -> FIX, so DONE_0 is high in cycle 2 with the special-case result above.
  - Detection also covers A==0, which returns 0 for all four ops.
- Undefined: every operation takes the full 34 cycles. Results are bit-identical to the defined build.

Test Plan:
- DIVU A=100, B=7, START_0 in cycle 0 -> BUSY_0 high in cycles 1..33, DONE_0 pulse in cycle 34, RESULT_0=14. Repeat with REMU -> RESULT_0=2.
- DIV A=-7 (0xFFFFFFF9), B=2 -> RESULT_0=0xFFFFFFFD (-3). REM with the same operands -> RESULT_0=0xFFFFFFFF (-1). REM A=7, B=-2 -> RESULT_0=1.
- DIV and REMU with B=0, A=0x12345678 -> 0xFFFFFFFF and 0x12345678 respectively. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. Checked with DIVIDER_FAST_SPECIAL_EN (DONE_0 in cycle 2) and without it (DONE_0 in cycle 34).
- START_0 pulsed again in cycle 10 with different operands -> ignored; the cycle-34 result matches the first operation.
- Back-to-back: second START_0 asserted in the DONE cycle (34) -> second DONE_0 in cycle 68 with the correct result; the first result is visible in cycle 34.
- ABORT_0 in cycle 15 -> BUSY_0=0 in cycle 16, no DONE_0, RESULT_0 unchanged. RST_0 in cycle 20 of a new operation -> all outputs 0 next cycle, no DONE_0. A START_0 and ABORT_0 in the same cycle -> no operation starts.
